// File: rtl/mcycle_pkg.sv
// mcycle_pkg: operation and FSM state encodings for the multi-cycle mul/div unit
package mcycle_pkg;
    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_FIXUP
    } state_e;
endpackage

// File: rtl/mcycle_core.sv
// mcycle_core: unsigned radix-2 datapath, shift-add multiply / restoring divide, one iteration per en
// Ports: clk, rst (async, active-high); load latches a, b, is_div and clears the counter;
//        en runs one iteration; acc is product (mul) or {remainder, quotient} (div);
//        last flags the final iteration.
module mcycle_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   b_q;
    logic               div_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] acc_nx;

    // rem_sh is one bit wider than the divisor: the shifted partial remainder can reach 2*b-1.
    // When ge holds the difference is below b, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        ge     = rem_sh >= {1'b0, b_q};
        diff   = rem_sh[WIDTH-1:0] - b_q;
        acc_nx = div_q  ? {ge ? diff : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge} :
                 acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end

    assign last = cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
            div_q <= is_div;
            cnt   <= '0;
        end else if (en) begin
            acc   <= acc_nx;
            cnt   <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/mcycle_muldiv.sv
// mcycle_muldiv: multi-cycle signed/unsigned multiply and divide unit with Done, DivByZero and Abort
// Ports: CLK, RESET (async, active-high); Start/Abort control; MCycleOp selects op;
//        Operand1/Operand2 in; Result1 = product low / quotient, Result2 = product high / remainder;
//        Busy, Done (one-cycle pulse), DivByZero registered status.
module mcycle_muldiv
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    state_e             state, state_nx;
    logic               sgn, div_in, a_neg, b_neg, zero_div, launch, fire, last;
    logic               div_q, dz_q, dz_wait, res_neg, rem_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, dividend, quo, rem, res1, res2;
    logic [2*WIDTH-1:0] acc, prod;

    mcycle_core #(.WIDTH(WIDTH)) u_core (
        .clk    (CLK),
        .rst    (RESET),
        .load   (launch),
        .en     (state == S_COMPUTE),
        .is_div (div_in),
        .a      (mag_a),
        .b      (mag_b),
        .acc    (acc),
        .last   (last)
    );

    // dz_wait holds a divide-by-zero in FIXUP for one extra cycle so its Done lands after launch+2.
    always_comb begin
        sgn      = ~MCycleOp[0];
        div_in   = MCycleOp[1];
        a_neg    = sgn & Operand1[WIDTH-1];
        b_neg    = sgn & Operand2[WIDTH-1];
        mag_a    = a_neg ? -Operand1 : Operand1;
        mag_b    = b_neg ? -Operand2 : Operand2;
        zero_div = div_in && (Operand2 == '0);
        launch   = (state == S_IDLE) && Start;
        state_nx = state;
        fire     = 1'b0;
        case (state)
            S_IDLE:    if (Start) state_nx = zero_div ? S_FIXUP : S_COMPUTE;
            S_COMPUTE: state_nx = Abort ? S_IDLE : last ? S_FIXUP : S_COMPUTE;
            S_FIXUP: begin
                if (Abort) state_nx = S_IDLE;
                else if (!dz_wait) begin
                    state_nx = S_IDLE;
                    fire     = 1'b1;
                end
            end
            default:   state_nx = S_IDLE;
        endcase
        prod = res_neg ? -acc : acc;
        quo  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res1 = dz_q ? '1 : div_q ? quo : prod[WIDTH-1:0];
        res2 = dz_q ? dividend : div_q ? rem : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            dz_wait   <= 1'b0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            dividend  <= '0;
            Result1   <= '0;
            Result2   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            state <= state_nx;
            Busy  <= state_nx != S_IDLE;
            Done  <= fire;
            if (launch) begin
                div_q    <= div_in;
                dz_q     <= zero_div;
                dz_wait  <= zero_div;
                dividend <= Operand1;
                res_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
            end else begin
                dz_wait  <= 1'b0;
            end
            if (fire) begin
                Result1   <= res1;
                Result2   <= res2;
                DivByZero <= dz_q;
            end
        end
    end
endmodule

// File: tb/tb_mcycle_muldiv.sv
// tb_mcycle_muldiv: table-driven and scoreboard checks of mcycle_muldiv at WIDTH=4 and WIDTH=32
module tb_mcycle_muldiv;
    import mcycle_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        dz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, start4 = 1'b0, start32 = 1'b0, abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0, opb = '0;
    logic [3:0]  r1_4, r2_4;
    logic [31:0] r1_32, r2_32;
    logic        busy4, done4, dz4, busy32, done32, dz32;
    int          checks = 0, errors = 0;
    vec_t        sb[$];
    vec_t        tbl[12];

    always #5 clk = ~clk;

    mcycle_muldiv #(.WIDTH(4)) dut4 (
        .CLK(clk), .RESET(rst), .Start(start4), .Abort(abort), .MCycleOp(op),
        .Operand1(opa[3:0]), .Operand2(opb[3:0]), .Result1(r1_4), .Result2(r2_4),
        .Busy(busy4), .Done(done4), .DivByZero(dz4)
    );

    mcycle_muldiv #(.WIDTH(32)) dut32 (
        .CLK(clk), .RESET(rst), .Start(start32), .Abort(abort), .MCycleOp(op),
        .Operand1(opa), .Operand2(opb), .Result1(r1_32), .Result2(r2_32),
        .Busy(busy32), .Done(done32), .DivByZero(dz32)
    );

    function automatic vec_t mk(logic [1:0] o, logic [31:0] a, logic [31:0] b,
                                logic [31:0] r1, logic [31:0] r2, logic dz, int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.r1 = r1; v.r2 = r2; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    function automatic vec_t ref32(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        vec_t   v;
        longint p;
        v = mk(o, a, b, 0, 0, 1'b0, 33);
        if (!o[1]) begin
            p = o[0] ? longint'({32'b0, a} * {32'b0, b}) : longint'($signed(a)) * longint'($signed(b));
            v.r1 = p[31:0];
            v.r2 = p[63:32];
        end else if (b == 0) begin
            v.r1 = '1; v.r2 = a; v.dz = 1'b1; v.lat = 2;
        end else if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                v.r1 = a; v.r2 = 0;
            end else begin
                v.r1 = $signed(a) / $signed(b);
                v.r2 = $signed(a) % $signed(b);
            end
        end else begin
            v.r1 = a / b; v.r2 = a % b;
        end
        return v;
    endfunction

    function automatic logic [31:0] g_r1(bit s);  return s ? r1_32 : {28'b0, r1_4}; endfunction
    function automatic logic [31:0] g_r2(bit s);  return s ? r2_32 : {28'b0, r2_4}; endfunction
    function automatic logic        g_bsy(bit s); return s ? busy32 : busy4;        endfunction
    function automatic logic        g_don(bit s); return s ? done32 : done4;        endfunction
    function automatic logic        g_dz(bit s);  return s ? dz32 : dz4;            endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(bit s, vec_t v);
        op = v.op; opa = v.a; opb = v.b;
        if (s) start32 = 1'b1; else start4 = 1'b1;
        sb.push_back(v);
    endtask

    // Called at the negedge after the launch edge; k counts edges since launch.
    task automatic wait_result(bit s, string name);
        int   k = 0;
        vec_t e;
        while (!g_don(s) && k < 100) begin
            step();
            k++;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty at Done", name);
            return;
        end
        e = sb.pop_front();
        check({name, " latency"}, 32'(k), 32'(e.lat));
        check({name, " r1"}, g_r1(s), e.r1);
        check({name, " r2"}, g_r2(s), e.r2);
        check({name, " dz"}, 32'(g_dz(s)), 32'(e.dz));
    endtask

    task automatic run(bit s, vec_t v, string name);
        drive(s, v);
        step();
        check({name, " busy"}, 32'(g_bsy(s)), 1);
        start4 = 1'b0; start32 = 1'b0;
        op = 2'($urandom); opa = $urandom; opb = $urandom;
        wait_result(s, name);
    endtask

    task automatic no_done(string name);
        logic seen = 1'b0;
        repeat (8) begin
            step();
            if (done4) seen = 1'b1;
        end
        check(name, 32'(seen), 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        tbl[0]  = mk(OP_SDIV, 'h9, 'h3, 'hE, 'hF, 1'b0, 5);
        tbl[1]  = mk(OP_UDIV, 'hE, 'hF, 'h0, 'hE, 1'b0, 5);
        tbl[2]  = mk(OP_SDIV, 'h8, 'hF, 'h8, 'h0, 1'b0, 5);
        tbl[3]  = mk(OP_UDIV, 'h5, 'h0, 'hF, 'h5, 1'b1, 2);
        tbl[4]  = mk(OP_UMUL, 'h3, 'h3, 'h9, 'h0, 1'b0, 5);
        tbl[5]  = mk(OP_SDIV, 'h7, 'h0, 'hF, 'h7, 1'b1, 2);
        tbl[6]  = mk(OP_SMUL, 'h8, 'h8, 'h0, 'h4, 1'b0, 5);
        tbl[7]  = mk(OP_SDIV, 'h7, 'hE, 'hD, 'h1, 1'b0, 5);
        tbl[8]  = mk(OP_SDIV, 'h9, 'h2, 'hD, 'hF, 1'b0, 5);
        tbl[9]  = mk(OP_UMUL, 'hF, 'hF, 'h1, 'hE, 1'b0, 5);
        tbl[10] = mk(OP_SMUL, 'h7, 'h8, 'h8, 'hC, 1'b0, 5);
        tbl[11] = mk(OP_UDIV, 'h0, 'h3, 'h0, 'h0, 1'b0, 5);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset r1", g_r1(0), 0);
        check("reset r2", g_r2(0), 0);
        check("reset busy", 32'(busy4), 0);
        check("reset done", 32'(done4), 0);
        check("reset dz", 32'(dz4), 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) run(0, tbl[i], $sformatf("vec%0d", i));

        // back-to-back with Start held high: one idle cycle carrying Done, then relaunch
        drive(0, mk(OP_SMUL, 'h9, 'h7, 'hF, 'hC, 1'b0, 5));
        step();
        wait_result(0, "b2b smul");
        check("b2b gap busy", 32'(busy4), 0);
        drive(0, mk(OP_UMUL, 'h3, 'h3, 'h9, 'h0, 1'b0, 5));
        step();
        check("b2b relaunch busy", 32'(busy4), 1);
        start4 = 1'b0;
        wait_result(0, "b2b umul");

        // abort after two iterations leaves earlier results in place
        run(0, mk(OP_UDIV, 'hE, 'hF, 'h0, 'hE, 1'b0, 5), "pre abort");
        op = OP_UMUL; opa = 'hF; opb = 'hF; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", 32'(busy4), 0);
        check("abort done", 32'(done4), 0);
        check("abort r1 kept", g_r1(0), 'h0);
        check("abort r2 kept", g_r2(0), 'hE);
        no_done("abort no done");

        // abort in FIXUP wins over completion
        op = OP_SMUL; opa = 'h7; opb = 'h7; start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("fixup abort busy", 32'(busy4), 0);
        check("fixup abort r2 kept", g_r2(0), 'hE);
        no_done("fixup abort no done");

        // abort during divide-by-zero FIXUP leaves DivByZero untouched
        op = OP_UDIV; opa = 'h5; opb = 'h0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("dz abort busy", 32'(busy4), 0);
        check("dz abort dz kept", 32'(dz4), 0);
        check("dz abort r1 kept", g_r1(0), 'h0);
        no_done("dz abort no done");

        // abort in IDLE is ignored and Start on the same edge launches
        abort = 1'b1;
        drive(0, mk(OP_UMUL, 'h2, 'h3, 'h6, 'h0, 1'b0, 5));
        step();
        abort = 1'b0; start4 = 1'b0;
        check("idle abort busy", 32'(busy4), 1);
        wait_result(0, "idle abort op");

        // asynchronous reset mid-COMPUTE clears every output at once
        run(0, mk(OP_UDIV, 'h5, 'h0, 'hF, 'h5, 1'b1, 2), "pre reset");
        op = OP_UMUL; opa = 'h3; opb = 'h5; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst r1", g_r1(0), 0);
        check("async rst r2", g_r2(0), 0);
        check("async rst busy", 32'(busy4), 0);
        check("async rst done", 32'(done4), 0);
        check("async rst dz", 32'(dz4), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run(0, mk(OP_UMUL, 'h2, 'h2, 'h4, 'h0, 1'b0, 5), "after reset");

        // WIDTH=32
        run(1, mk(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33), "w32 umul max");
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                default: b = $urandom;
            endcase
            run(1, ref32(o, a, b), $sformatf("w32 rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
